// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified memory arbiter: widths, defaults,
// grant encoding and a saturating-increment helper for the starvation counter.
`ifndef CPU6_XLEN
`define CPU6_XLEN 64
`endif

package unified_mem_arbiter_pkg;

  localparam int unsigned UMA_AW         = 8;
  localparam int unsigned UMA_XLEN       = `CPU6_XLEN;
  localparam int unsigned UMA_STARVE_MAX = 3;
  localparam int unsigned UMA_STARVE_W   = 4;
  localparam int unsigned UMA_PERF_W     = 16;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UMA_STARVE_W-1:0] starve_inc(
    input logic [UMA_STARVE_W-1:0] v
  );
    return (v == '1) ? v : v + UMA_STARVE_W'(1);
  endfunction

endpackage

// File: rtl/uma_perf_counters.sv
// Saturating performance counters for the unified memory arbiter.
// Present only when UNIFIED_MEM_ARB_PERF_EN is defined.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   if_gnt, d_gnt      grant strobes from the arbiter
//   conflict           both requesters active this cycle
//   perf_if_gnt        count of IF grants
//   perf_d_gnt         count of D grants
//   perf_conflict      count of cycles with both requests high
`ifdef UNIFIED_MEM_ARB_PERF_EN
module uma_perf_counters
  import unified_mem_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  if_gnt,
  input  logic                  d_gnt,
  input  logic                  conflict,
  output logic [UMA_PERF_W-1:0] perf_if_gnt,
  output logic [UMA_PERF_W-1:0] perf_d_gnt,
  output logic [UMA_PERF_W-1:0] perf_conflict
);

  // Each counter stops at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_if_gnt   <= '0;
      perf_d_gnt    <= '0;
      perf_conflict <= '0;
    end else begin
      if (if_gnt && (perf_if_gnt != '1))
        perf_if_gnt <= perf_if_gnt + UMA_PERF_W'(1);
      if (d_gnt && (perf_d_gnt != '1))
        perf_d_gnt <= perf_d_gnt + UMA_PERF_W'(1);
      if (conflict && (perf_conflict != '1))
        perf_conflict <= perf_conflict + UMA_PERF_W'(1);
    end
  end

endmodule
`endif

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory (combinational read, synchronous write)
// between the instruction-fetch port (IF) and the load/store port (D).
// D has fixed priority; IF is forced through after STARVE_MAX consecutive
// denials. Grants are combinational, responses are registered one cycle later.
// Optional: define UNIFIED_MEM_ARB_PERF_EN to add perf_if_gnt, perf_d_gnt and
// perf_conflict saturating counters.
// Ports:
//   clk, resetn                          clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt             fetch request and accept
//   if_rvalid/if_rdata                   fetch response
//   d_req/d_we/d_addr/d_wdata -> d_gnt   data request and accept
//   d_rvalid/d_rdata                     data response (0 data for writes)
//   mem_a/mem_we/mem_wd, mem_rd          backing memory interface
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = UMA_AW,
  parameter int unsigned XLEN       = UMA_XLEN,
  parameter int unsigned STARVE_MAX = UMA_STARVE_MAX
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic [AW-1:0]   mem_a,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
`ifdef UNIFIED_MEM_ARB_PERF_EN
  ,
  output logic [UMA_PERF_W-1:0] perf_if_gnt,
  output logic [UMA_PERF_W-1:0] perf_d_gnt,
  output logic [UMA_PERF_W-1:0] perf_conflict
`endif
);

  logic [UMA_STARVE_W-1:0] starve_cnt;
  logic [1:0]              gnt_sel;
  logic                    if_starved;

  assign if_starved = (starve_cnt >= UMA_STARVE_W'(STARVE_MAX));

  // D wins a conflict unless IF has been denied STARVE_MAX times in a row.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (d_req && !(if_req && if_starved))
      gnt_sel = GNT_D;
    else if (if_req)
      gnt_sel = GNT_IF;
  end

  assign if_gnt = (gnt_sel == GNT_IF);
  assign d_gnt  = (gnt_sel == GNT_D);

  // Memory is driven only by the granted side; idle cycles drive zeros.
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    if (gnt_sel == GNT_IF) begin
      mem_a = if_addr;
    end else if (gnt_sel == GNT_D) begin
      mem_a  = d_addr;
      mem_we = d_we;
      mem_wd = d_wdata;
    end
  end

  // Response registers and starvation tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      if_rvalid <= if_gnt;
      d_rvalid  <= d_gnt;
      if (if_gnt)
        if_rdata <= mem_rd;
      if (d_gnt)
        d_rdata <= d_we ? '0 : mem_rd;
      if (if_req && !if_gnt)
        starve_cnt <= starve_inc(starve_cnt);
      else
        starve_cnt <= '0;
    end
  end

`ifdef UNIFIED_MEM_ARB_PERF_EN
  uma_perf_counters u_perf (
    .clk          (clk),
    .resetn       (resetn),
    .if_gnt       (if_gnt),
    .d_gnt        (d_gnt),
    .conflict     (if_req && d_req),
    .perf_if_gnt  (perf_if_gnt),
    .perf_d_gnt   (perf_d_gnt),
    .perf_conflict(perf_conflict)
  );
`endif

endmodule
